// File: rtl/register_load_arbiter.sv
// register_load_arbiter: shares one load register among REQUESTER_COUNT
// requesters. A winner gets one GRANT cycle, one LOAD cycle driving the
// register pins, and one DONE cycle in which the register output holds its
// data. An IDLE cycle always separates transfers.
//
// Optional feature: define LOAD_ARBITER_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise the lowest requesting index always wins and the
// priority pointer stays at 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no transfer; arbitrate among raised requests
// S_GRANT | winner announced; check it is still requesting, capture data
// S_LOAD  | enable/load pulse with the captured data on the register pins
// S_DONE  | register output valid; winner told; pointer advanced

module register_load_arbiter #(
  parameter int REQUESTER_COUNT = 4,
  parameter int DATA_WIDTH      = 18,
  parameter int INDEX_WIDTH     = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [REQUESTER_COUNT-1:0]            request,
  input  logic [REQUESTER_COUNT*DATA_WIDTH-1:0] request_data,
  output logic [REQUESTER_COUNT-1:0]            grant,
  output logic [REQUESTER_COUNT-1:0]            done,
  output logic [DATA_WIDTH-1:0]                 register_data_input,
  output logic                                  register_enable,
  output logic                                  register_load,
  output logic                                  busy,
  output logic [INDEX_WIDTH-1:0]                owner_index
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [REQUESTER_COUNT-1:0]   r_grant;
  logic [REQUESTER_COUNT-1:0]   w_grant_nxt;
  logic [REQUESTER_COUNT-1:0]   r_done;
  logic [REQUESTER_COUNT-1:0]   w_done_nxt;
  // The data output register doubles as the hold register: it is written
  // only on the GRANT->LOAD edge and cleared on every other edge.
  logic [DATA_WIDTH-1:0]        r_hold;
  logic [DATA_WIDTH-1:0]        w_hold_nxt;
  logic                         r_load_pulse;
  logic                         w_load_pulse_nxt;
  logic                         r_busy;
  logic [INDEX_WIDTH-1:0]       r_owner;
  logic [INDEX_WIDTH-1:0]       w_owner_nxt;
  logic [INDEX_WIDTH-1:0]       r_pointer;
  logic [INDEX_WIDTH-1:0]       w_pointer_nxt;
  logic [INDEX_WIDTH-1:0]       w_winner;
  logic                         w_found;
  logic [INDEX_WIDTH:0]         w_cand;
  logic [DATA_WIDTH-1:0]        w_owner_data;

  assign grant               = r_grant;
  assign done                = r_done;
  assign register_data_input = r_hold;
  assign register_enable     = r_load_pulse;
  assign register_load       = r_load_pulse;
  assign busy                = r_busy;
  assign owner_index         = r_owner;

  assign w_owner_data = request_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];

  // Winner search: first raised request starting at the pointer, wrapping.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      w_cand = {1'b0, r_pointer} + (INDEX_WIDTH+1)'(i);
      if (w_cand >= (INDEX_WIDTH+1)'(REQUESTER_COUNT)) begin
        w_cand = w_cand - (INDEX_WIDTH+1)'(REQUESTER_COUNT);
      end
      if (!w_found && request[w_cand[INDEX_WIDTH-1:0]]) begin
        w_winner = w_cand[INDEX_WIDTH-1:0];
        w_found  = 1'b1;
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = '0;
    w_done_nxt       = '0;
    w_hold_nxt       = '0;
    w_load_pulse_nxt = 1'b0;
    w_owner_nxt      = r_owner;
    w_pointer_nxt    = r_pointer;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt           = S_GRANT;
          w_grant_nxt[w_winner] = 1'b1;
          w_owner_nxt           = w_winner;
        end
      end
      S_GRANT: begin
        if (request[r_owner]) begin
          w_state_nxt      = S_LOAD;
          w_hold_nxt       = w_owner_data;
          w_load_pulse_nxt = 1'b1;
        end else begin
          // Withdrawn request: abort without touching the pointer.
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_state_nxt         = S_DONE;
        w_done_nxt[r_owner] = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
`ifdef LOAD_ARBITER_ROUND_ROBIN_EN
        if (r_owner == INDEX_WIDTH'(REQUESTER_COUNT-1)) begin
          w_pointer_nxt = '0;
        end else begin
          w_pointer_nxt = r_owner + INDEX_WIDTH'(1);
        end
`else
        w_pointer_nxt = '0;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_done       <= '0;
      r_hold       <= '0;
      r_load_pulse <= 1'b0;
      r_busy       <= 1'b0;
      r_owner      <= '0;
      r_pointer    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_done       <= w_done_nxt;
      r_hold       <= w_hold_nxt;
      r_load_pulse <= w_load_pulse_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_owner      <= w_owner_nxt;
      r_pointer    <= w_pointer_nxt;
    end
  end

endmodule

// File: tb/tb_register_load_arbiter.sv
// Scoreboard bench for register_load_arbiter. The stimulus process issues
// transfers and queues the expected grant, load and done events (with the
// cycle each must appear in); a negedge monitor pops and compares them.
module tb_register_load_arbiter;
  localparam int N  = 4;
  localparam int DW = 18;

  logic            clock;
  logic            reset_n;
  logic [N-1:0]    request;
  logic [N*DW-1:0] request_data;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [DW-1:0]   register_data_input;
  logic            register_enable;
  logic            register_load;
  logic            busy;
  logic [1:0]      owner_index;

  typedef struct {
    int          cyc;
    logic [N-1:0] vec;
    int          idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t grant_q[$];
  exp_t load_q[$];
  exp_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_ptr  = 0;
  logic [DW-1:0] reg_q;
  logic prev_load = 1'b0;

  register_load_arbiter dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .request             (request),
    .request_data        (request_data),
    .grant               (grant),
    .done                (done),
    .register_data_input (register_data_input),
    .register_enable     (register_enable),
    .register_load       (register_load),
    .busy                (busy),
    .owner_index         (owner_index)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Model of the downstream register: loads when enable and load are both
  // high, clears otherwise.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) reg_q <= '0;
    else reg_q <= (register_enable && register_load) ? register_data_input : '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int arbitrate(input logic [N-1:0] v);
    int j;
`ifdef LOAD_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (v[j]) return j;
    end
`else
    for (int k = 0; k < N; k++) begin
      j = k;
      if (v[j]) return j;
    end
`endif
    return 0;
  endfunction

  // Monitor: every DUT event must match the head of its queue.
  always @(negedge clock) begin : mon
    exp_t e;
    if (grant_q.size() > 0 && grant_q[0].cyc < cyc) begin
      e = grant_q.pop_front();
      checks++; errors++;
      $display("FAIL grant_missing: grant absent, required at cycle %0d", e.cyc);
    end
    if (load_q.size() > 0 && load_q[0].cyc < cyc) begin
      e = load_q.pop_front();
      checks++; errors++;
      $display("FAIL load_missing: load pulse absent, required at cycle %0d", e.cyc);
    end
    if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
      e = done_q.pop_front();
      checks++; errors++;
      $display("FAIL done_missing: done absent, required at cycle %0d", e.cyc);
    end

    if (grant != '0) begin
      if (grant_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_unexpected: got %0h, expected none (cycle %0d)", grant, cyc);
      end else begin
        e = grant_q.pop_front();
        chk("grant_vec", grant, e.vec);
        chk("grant_cycle", cyc, e.cyc);
        chk("owner_index", owner_index, e.idx);
      end
    end

    if (register_load || register_enable) begin
      if (load_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL load_unexpected: got load=%0b enable=%0b, expected none (cycle %0d)",
                 register_load, register_enable, cyc);
      end else begin
        e = load_q.pop_front();
        chk("load_pins", {register_enable, register_load}, 2'b11);
        chk("load_data", register_data_input, e.data);
        chk("load_cycle", cyc, e.cyc);
      end
      chk("load_back_to_back", prev_load & register_load, 0);
    end else begin
      chk("data_idle_zero", register_data_input, 0);
    end
    prev_load = register_load;

    if (done != '0) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got %0h, expected none (cycle %0d)", done, cyc);
      end else begin
        e = done_q.pop_front();
        chk("done_vec", done, e.vec);
        chk("done_cycle", cyc, e.cyc);
        chk("register_output", reg_q, e.data);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, register_data_input, 0);
    chk({tag, "_enable"}, register_enable, 0);
    chk({tag, "_load"}, register_load, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner_index, 0);
  endtask

  // Called one time unit after an edge with the DUT idle; the new request
  // vector is arbitrated on the next edge.
  task automatic run_round(input logic [N-1:0] vec, input bit abort_it,
                           input logic [N-1:0] raise_mid, input bit reset_mid,
                           input bit use_fixed, input logic [DW-1:0] fixed_data);
    int   w;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      request_data[i*DW +: DW] = use_fixed ? fixed_data : DW'($urandom);
    end
    request = vec;
    w = arbitrate(vec);
    e.cyc = cyc + 1;
    e.vec = '0;
    e.vec[w] = 1'b1;
    e.idx = w;
    e.data = request_data[w*DW +: DW];
    grant_q.push_back(e);
    @(posedge clock); #1;
    chk("busy_in_grant", busy, 1);
    if (abort_it) begin
      request[w] = 1'b0;
      @(posedge clock); #1;
      chk("busy_after_abort", busy, 0);
      return;
    end
    e.cyc = cyc + 1;
    load_q.push_back(e);
    e.cyc = cyc + 2;
    done_q.push_back(e);
    @(posedge clock); #1;
    request = request | raise_mid;
    if (reset_mid) begin
      reset_n = 1'b0;
      load_q.delete();
      done_q.delete();
      m_ptr = 0;
      #1;
      check_outputs_zero("reset_mid_load");
      request = '0;
      @(posedge clock); @(posedge clock); #1;
      reset_n = 1'b1;
      #1;
      chk("busy_after_release", busy, 0);
      return;
    end
    @(posedge clock); #1;
    request[w] = 1'b0;
`ifdef LOAD_ARBITER_ROUND_ROBIN_EN
    m_ptr = (w + 1) % N;
`endif
    @(posedge clock); #1;
    chk("busy_back_in_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] v;
    reset_n      = 1'b1;
    request      = '0;
    request_data = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("idle_without_request", busy, 0);

    run_round(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 18'h2AAAA);
    run_round(4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, '0);
    repeat (5) run_round(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, '0);
    run_round(4'b0010, 1'b0, 4'b1000, 1'b0, 1'b0, '0);
    run_round(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, '0);
    run_round(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, '0);
    run_round(4'b1100, 1'b0, 4'b0000, 1'b1, 1'b0, '0);
    run_round(4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, '0);

    for (int r = 0; r < 40; r++) begin
      v = N'($urandom_range(0, 15));
      if (v == '0) begin
        request = '0;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end else begin
        run_round(v, ($urandom_range(0, 4) == 0), N'($urandom), 1'b0, 1'b0, '0);
      end
    end

    request = '0;
    repeat (6) @(posedge clock);
    #1;
    chk("grant_queue_drained", grant_q.size(), 0);
    chk("load_queue_drained", load_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_load_arbiter.md
# register_load_arbiter

Shares one 18-bit load register among several requesters. Each requester raises a request with its data. The arbiter picks one winner and drives the register's `data_input`/`enable`/`load` pins for exactly one load cycle. It then tells the winner its data is visible on the register output. It sits directly in front of `register_18bit` and is the only block allowed to drive that register's control pins.

## Interface
Parameters:
- `REQUESTER_COUNT`, default 4: number of requesters; legal range 2..8.
- `DATA_WIDTH`, default 18: width of the data path; must match the register.
- `INDEX_WIDTH`, default 2: width of the owner index; equals clog2(`REQUESTER_COUNT`), minimum 1.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `request`  in  REQUESTER_COUNT: one request line per requester; held high until `done` or until the requester withdraws.
- `request_data`  in  REQUESTER_COUNT*DATA_WIDTH: requester i's data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grant`  out  REQUESTER_COUNT: one-hot; high for the single GRANT cycle of the winner.
- `done`  out  REQUESTER_COUNT: one-hot; high for the single DONE cycle of the winner.
- `register_data_input`  out  DATA_WIDTH: drives the register's `data_input`.
- `register_enable`  out  1: drives the register's `enable`.
- `register_load`  out  1: drives the register's `load`.
- `busy`  out  1: high whenever the state is not IDLE.
- `owner_index`  out  INDEX_WIDTH: index of the current or most recent winner.

## Operation
- All outputs are registered.
- Reset values: `grant`=0, `done`=0, `register_data_input`=0, `register_enable`=0, `register_load`=0, `busy`=0, `owner_index`=0.
- On reset the state goes to IDLE and the priority pointer goes to 0.
- State machine:
  - **IDLE**: if `request`≠0, select the winner (see Configuration). Set `grant[winner]`=1 and `owner_index`=winner, then go to GRANT. Otherwise stay in IDLE.
  - **GRANT**: if `request[owner_index]` is still high, capture its slice of `request_data` into the hold register and go to LOAD. If the request has dropped, this is an abort: go to IDLE with no load pulse and no `done`, and leave the priority pointer unchanged.
  - **LOAD**: drive `register_enable`=`register_load`=1 and `register_data_input`=hold for one cycle. Go to DONE.
  - **DONE**: `done[owner_index]`=1. The register output equals the hold value in this cycle. Advance the priority pointer, then go to IDLE.
- Outside LOAD, `register_enable`, `register_load` and `register_data_input` are all 0. The register clears whenever enable and load are not both high, so its output is valid only during the DONE cycle. Consumers sample it then.
- Request changes outside IDLE and GRANT are ignored. A new request arriving mid-transfer waits for IDLE.
- A requester must drop `request` in the cycle after its `done`, or it is eligible again in the next IDLE.

## Timing
- Request high before edge 0, state in IDLE:
  - edge 0: GRANT (`grant` high);
  - edge 1: LOAD (load pulse);
  - edge 2: register output = data, DONE (`done` high);
  - edge 3: IDLE.
- Throughput: one transfer per 4 cycles; the IDLE cycle between transfers is mandatory.
- `reset_n` low at any point, including mid-LOAD, clears all outputs immediately and asynchronously. No partial load is completed after reset is released.
- The first arbitration is made on the first rising edge after `reset_n` rises.

## Configuration
- `LOAD_ARBITER_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - Search order starts at the priority pointer and wraps modulo REQUESTER_COUNT.
  - After a completed transfer by winner w, the pointer becomes (w+1) mod REQUESTER_COUNT.
  - Aborts do not move the pointer.
- Not defined: fixed priority; the lowest index wins and the pointer is unused (it stays at 0).

## Test plan
- Reset, then `request`=4'b0010 with data 18'h2AAAA → `grant`=4'b0010 at edge 0, load pulse at edge 1 with `register_data_input`=18'h2AAAA, `done`=4'b0010 and register output 18'h2AAAA at edge 2, back to IDLE at edge 3.
- `request`=4'b1111 held, round-robin enabled → winners in order 0,1,2,3,0, with 4 cycles per transfer. With the macro undefined → requester 0 wins every time.
- Requester 2 drops `request` during GRANT → no load pulse, no `done`, IDLE next cycle, pointer unchanged (requester 2 wins next if it re-requests first in order).
- `reset_n` driven low midway through LOAD → all outputs are 0 before the next edge; after release, `busy`=0 and the next arbitration starts from requester 0.
- Requester 3 raises `request` while requester 1 is in LOAD → requester 3 is granted only at the edge after requester 1's DONE cycle has returned the state to IDLE; `register_load` is never high for 2 consecutive cycles.
